// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module : pipeline_hazard_ctrl
// Desc   : Stall/flush scheduler for a 5-stage pipeline. Handles load-use
//          hazards, EX redirects, IF/MEM wait states and debug halt drain.
// Rev    : 1.0
// ============================================================================
module pipeline_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 4,
  parameter int TIMEOUT      = 255,
  parameter int CNT_W        = 32
) (
  input  logic             clk_i,
  input  logic             n_rst,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_rs1_used_i,
  input  logic             id_rs2_used_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_memread_en_i,
  input  logic             ex_redirect_i,
  input  logic             imem_ready_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  input  logic             halt_req_i,
  input  logic             resume_i,
  output logic             pc_stall_o,
  output logic             if_id_stall_o,
  output logic             if_id_flush_o,
  output logic             id_ex_stall_o,
  output logic             id_ex_flush_o,
  output logic             ex_mem_stall_o,
  output logic             mem_wb_flush_o,
  output logic             halted_o,
  output logic             mem_timeout_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam int WAIT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int DRAIN_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

  localparam logic [WAIT_W-1:0]  c_timeout    = WAIT_W'(TIMEOUT);
  localparam logic [DRAIN_W-1:0] c_drain_init = DRAIN_W'(DRAIN_CYCLES);
  localparam logic [DRAIN_W-1:0] c_drain_last = DRAIN_W'(1);

  localparam logic [1:0] c_st_run      = 2'd0;
  localparam logic [1:0] c_st_mem_wait = 2'd1;
  localparam logic [1:0] c_st_drain    = 2'd2;
  localparam logic [1:0] c_st_halted   = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [1:0]       ret_state_q, ret_state_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic w_mem_hold;
  logic w_load_use;
  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_mem_hold = mem_req_i & ~mem_ack_i;
  assign w_rs1_hit  = id_rs1_used_i & (id_rs1_i == ex_rd_i);
  assign w_rs2_hit  = id_rs2_used_i & (id_rs2_i == ex_rd_i);
  assign w_load_use = ex_memread_en_i & (ex_rd_i != 5'd0) & (w_rs1_hit | w_rs2_hit);

  // Priority chain: memory hold, redirect, load-use, drain/halt bubble, fetch wait.
  always_comb begin
    pc_stall_o     = 1'b0;
    if_id_stall_o  = 1'b0;
    if_id_flush_o  = 1'b0;
    id_ex_stall_o  = 1'b0;
    id_ex_flush_o  = 1'b0;
    ex_mem_stall_o = 1'b0;
    mem_wb_flush_o = 1'b0;
    if (w_mem_hold && (state_q != c_st_halted)) begin
      pc_stall_o     = 1'b1;
      if_id_stall_o  = 1'b1;
      id_ex_stall_o  = 1'b1;
      ex_mem_stall_o = 1'b1;
      mem_wb_flush_o = 1'b1;
    end else if (ex_redirect_i) begin
      if_id_flush_o = 1'b1;
      id_ex_flush_o = 1'b1;
    end else if (w_load_use && ((state_q == c_st_run) || (state_q == c_st_drain))) begin
      pc_stall_o    = 1'b1;
      if_id_stall_o = 1'b1;
      id_ex_flush_o = 1'b1;
    end else if ((state_q == c_st_drain) || (state_q == c_st_halted)) begin
      pc_stall_o    = 1'b1;
      if_id_flush_o = 1'b1;
    end else if ((state_q == c_st_run) && !imem_ready_i) begin
      pc_stall_o    = 1'b1;
      if_id_flush_o = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    ret_state_d = ret_state_q;
    wait_cnt_d  = wait_cnt_q;
    drain_cnt_d = drain_cnt_q;
    timeout_d   = timeout_q;
    case (state_q)
      c_st_run: begin
        if (w_mem_hold) begin
          state_d     = c_st_mem_wait;
          ret_state_d = c_st_run;
        end else if (halt_req_i) begin
          state_d     = c_st_drain;
          drain_cnt_d = c_drain_init;
        end
      end
      c_st_mem_wait: begin
        if (wait_cnt_q == c_timeout) begin
          timeout_d = 1'b1;
        end
        if (mem_ack_i) begin
          state_d    = ret_state_q;
          wait_cnt_d = '0;
        end else if (wait_cnt_q != c_timeout) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      c_st_drain: begin
        // The drain counter only advances on cycles the pipeline actually moves.
        if (w_mem_hold) begin
          state_d     = c_st_mem_wait;
          ret_state_d = c_st_drain;
        end else if (!w_load_use) begin
          if (drain_cnt_q <= c_drain_last) begin
            state_d     = c_st_halted;
            drain_cnt_d = '0;
          end else begin
            drain_cnt_d = drain_cnt_q - 1'b1;
          end
        end
      end
      c_st_halted: begin
        if (resume_i) begin
          state_d = c_st_run;
        end
      end
      default: begin
        state_d = c_st_run;
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (pc_stall_o && (state_q != c_st_halted)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= c_st_run;
      ret_state_q <= c_st_run;
      wait_cnt_q  <= '0;
      drain_cnt_q <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ret_state_q <= ret_state_d;
      wait_cnt_q  <= wait_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign state_o       = state_q;
  assign halted_o      = (state_q == c_st_halted);
  assign mem_timeout_o = timeout_q;
  assign stall_cnt_o   = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_pipeline_hazard_ctrl
// Desc   : Directed self-checking bench for pipeline_hazard_ctrl.
// Rev    : 1.0
// ============================================================================
module tb_pipeline_hazard_ctrl;

  logic        clk_i = 1'b0;
  logic        n_rst = 1'b1;
  logic [4:0]  id_rs1_i, id_rs2_i, ex_rd_i;
  logic        id_rs1_used_i, id_rs2_used_i, ex_memread_en_i, ex_redirect_i;
  logic        imem_ready_i, mem_req_i, mem_ack_i, halt_req_i, resume_i;
  logic        pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_stall_o;
  logic        id_ex_flush_o, ex_mem_stall_o, mem_wb_flush_o;
  logic        halted_o, mem_timeout_o;
  logic [1:0]  state_o;
  logic [31:0] stall_cnt_o;
  logic [6:0]  ctl;

  // {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush}
  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_LU   = 7'b1100100;
  localparam logic [6:0] C_MEM  = 7'b1101011;
  localparam logic [6:0] C_RDR  = 7'b0010100;
  localparam logic [6:0] C_HOLD = 7'b1010000;

  int n_pass  = 0;
  int n_total = 0;

  pipeline_hazard_ctrl #(
    .DRAIN_CYCLES(4),
    .TIMEOUT     (4),
    .CNT_W       (32)
  ) u_dut (
    .clk_i          (clk_i),
    .n_rst          (n_rst),
    .id_rs1_i       (id_rs1_i),
    .id_rs2_i       (id_rs2_i),
    .id_rs1_used_i  (id_rs1_used_i),
    .id_rs2_used_i  (id_rs2_used_i),
    .ex_rd_i        (ex_rd_i),
    .ex_memread_en_i(ex_memread_en_i),
    .ex_redirect_i  (ex_redirect_i),
    .imem_ready_i   (imem_ready_i),
    .mem_req_i      (mem_req_i),
    .mem_ack_i      (mem_ack_i),
    .halt_req_i     (halt_req_i),
    .resume_i       (resume_i),
    .pc_stall_o     (pc_stall_o),
    .if_id_stall_o  (if_id_stall_o),
    .if_id_flush_o  (if_id_flush_o),
    .id_ex_stall_o  (id_ex_stall_o),
    .id_ex_flush_o  (id_ex_flush_o),
    .ex_mem_stall_o (ex_mem_stall_o),
    .mem_wb_flush_o (mem_wb_flush_o),
    .halted_o       (halted_o),
    .mem_timeout_o  (mem_timeout_o),
    .state_o        (state_o),
    .stall_cnt_o    (stall_cnt_o)
  );

  assign ctl = {pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_stall_o,
                id_ex_flush_o, ex_mem_stall_o, mem_wb_flush_o};

  always #5 clk_i = ~clk_i;

  task automatic idle();
    id_rs1_i = 5'd0; id_rs2_i = 5'd0; ex_rd_i = 5'd0;
    id_rs1_used_i = 1'b0; id_rs2_used_i = 1'b0;
    ex_memread_en_i = 1'b0; ex_redirect_i = 1'b0;
    imem_ready_i = 1'b1; mem_req_i = 1'b0; mem_ack_i = 1'b0;
    halt_req_i = 1'b0; resume_i = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_load_use();
    ex_memread_en_i = 1'b1; ex_rd_i = 5'd5; id_rs2_i = 5'd5; id_rs2_used_i = 1'b1;
  endtask

  task automatic do_reset();
    idle();
    n_rst = 1'b0;
    #3;
    n_rst = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    #1 n_rst = 1'b0;
    #11;
    n_total++; if (ctl !== C_NONE) $display("FAIL rst_ctl: got %b want %b", ctl, C_NONE); else n_pass++;
    n_total++; if (state_o !== 2'd0) $display("FAIL rst_state: got %0d want 0", state_o); else n_pass++;
    n_total++; if (halted_o !== 1'b0) $display("FAIL rst_halted: got %b want 0", halted_o); else n_pass++;
    n_total++; if (mem_timeout_o !== 1'b0) $display("FAIL rst_timeout: got %b want 0", mem_timeout_o); else n_pass++;
    n_total++; if (stall_cnt_o !== 32'd0) $display("FAIL rst_cnt: got %0d want 0", stall_cnt_o); else n_pass++;
    tick();
    n_rst = 1'b1;
    tick();
    n_total++; if (ctl !== C_NONE) $display("FAIL rst_idle_ctl: got %b want %b", ctl, C_NONE); else n_pass++;
  endtask

  task automatic test_load_use();
    tick(); idle(); set_load_use(); #1;
    n_total++; if (ctl !== C_LU) $display("FAIL lu_ctl: got %b want %b", ctl, C_LU); else n_pass++;
    tick(); idle(); #1;
    n_total++; if (ctl !== C_NONE) $display("FAIL lu_one_bubble: got %b want %b", ctl, C_NONE); else n_pass++;
    n_total++; if (stall_cnt_o !== 32'd1) $display("FAIL lu_cnt: got %0d want 1", stall_cnt_o); else n_pass++;
    ex_memread_en_i = 1'b1; ex_rd_i = 5'd0; id_rs1_i = 5'd0; id_rs1_used_i = 1'b1; #1;
    n_total++; if (ctl !== C_NONE) $display("FAIL lu_x0: got %b want %b", ctl, C_NONE); else n_pass++;
    ex_rd_i = 5'd7; id_rs1_i = 5'd7; id_rs1_used_i = 1'b0; #1;
    n_total++; if (ctl !== C_NONE) $display("FAIL lu_unused: got %b want %b", ctl, C_NONE); else n_pass++;
    id_rs1_used_i = 1'b1; #1;
    n_total++; if (ctl !== C_LU) $display("FAIL lu_rs1: got %b want %b", ctl, C_LU); else n_pass++;
  endtask

  task automatic test_redirect();
    tick(); idle(); set_load_use(); ex_redirect_i = 1'b1; #1;
    n_total++; if (ctl !== C_RDR) $display("FAIL rdr_over_lu: got %b want %b", ctl, C_RDR); else n_pass++;
    tick(); idle(); #1;
    n_total++; if (stall_cnt_o !== 32'd2) $display("FAIL rdr_cnt: got %0d want 2", stall_cnt_o); else n_pass++;
    imem_ready_i = 1'b0; #1;
    n_total++; if (ctl !== C_HOLD) $display("FAIL imem_wait: got %b want %b", ctl, C_HOLD); else n_pass++;
    tick(); idle(); #1;
    n_total++; if (stall_cnt_o !== 32'd3) $display("FAIL imem_cnt: got %0d want 3", stall_cnt_o); else n_pass++;
  endtask

  task automatic test_mem_wait();
    tick(); idle(); mem_req_i = 1'b1; #1;
    n_total++; if (ctl !== C_MEM) $display("FAIL mw_first_ctl: got %b want %b", ctl, C_MEM); else n_pass++;
    n_total++; if (state_o !== 2'd0) $display("FAIL mw_first_state: got %0d want 0", state_o); else n_pass++;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_total++; if (ctl !== C_MEM) $display("FAIL mw_hold_ctl: got %b want %b", ctl, C_MEM); else n_pass++;
      n_total++; if (state_o !== 2'd1) $display("FAIL mw_hold_state: got %0d want 1", state_o); else n_pass++;
    end
    tick(); mem_ack_i = 1'b1; #1;
    n_total++; if (ctl !== C_NONE) $display("FAIL mw_ack_ctl: got %b want %b", ctl, C_NONE); else n_pass++;
    n_total++; if (state_o !== 2'd1) $display("FAIL mw_ack_state: got %0d want 1", state_o); else n_pass++;
    tick(); idle(); #1;
    n_total++; if (state_o !== 2'd0) $display("FAIL mw_ret_state: got %0d want 0", state_o); else n_pass++;
    n_total++; if (stall_cnt_o !== 32'd6) $display("FAIL mw_cnt: got %0d want 6", stall_cnt_o); else n_pass++;
    mem_req_i = 1'b1; mem_ack_i = 1'b1; #1;
    n_total++; if (ctl !== C_NONE) $display("FAIL mw_zero_wait_ctl: got %b want %b", ctl, C_NONE); else n_pass++;
    tick(); idle(); #1;
    n_total++; if (state_o !== 2'd0) $display("FAIL mw_zero_wait_state: got %0d want 0", state_o); else n_pass++;
  endtask

  task automatic test_timeout();
    do_reset();
    tick(); idle(); mem_req_i = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      if (c > 0) tick();
      if (c == 10) mem_ack_i = 1'b1;
      #1;
      if (c == 5) begin
        n_total++; if (mem_timeout_o !== 1'b0) $display("FAIL to_early: got %b want 0", mem_timeout_o); else n_pass++;
      end
      if (c >= 6) begin
        n_total++; if (mem_timeout_o !== 1'b1) $display("FAIL to_set c%0d: got %b want 1", c, mem_timeout_o); else n_pass++;
      end
    end
    tick(); idle(); #1;
    n_total++; if (state_o !== 2'd0) $display("FAIL to_ret_state: got %0d want 0", state_o); else n_pass++;
    n_total++; if (mem_timeout_o !== 1'b1) $display("FAIL to_sticky: got %b want 1", mem_timeout_o); else n_pass++;
    n_total++; if (stall_cnt_o !== 32'd10) $display("FAIL to_cnt: got %0d want 10", stall_cnt_o); else n_pass++;
    n_rst = 1'b0; #1;
    n_total++; if (mem_timeout_o !== 1'b0) $display("FAIL to_clear: got %b want 0", mem_timeout_o); else n_pass++;
    tick();
    n_rst = 1'b1;
  endtask

  task automatic test_halt_drain();
    do_reset();
    tick(); idle(); halt_req_i = 1'b1; #1;
    n_total++; if (ctl !== C_NONE) $display("FAIL halt_req_ctl: got %b want %b", ctl, C_NONE); else n_pass++;
    tick(); idle(); #1;
    n_total++; if (state_o !== 2'd2) $display("FAIL drain_state: got %0d want 2", state_o); else n_pass++;
    n_total++; if (ctl !== C_HOLD) $display("FAIL drain_ctl: got %b want %b", ctl, C_HOLD); else n_pass++;
    tick(); set_load_use(); #1;
    n_total++; if (ctl !== C_LU) $display("FAIL drain_lu: got %b want %b", ctl, C_LU); else n_pass++;
    tick(); idle(); #1;
    tick();
    tick();
    n_total++; if (halted_o !== 1'b0) $display("FAIL halt_early: got %b want 0", halted_o); else n_pass++;
    tick();
    n_total++; if (halted_o !== 1'b1) $display("FAIL halt_rise: got %b want 1", halted_o); else n_pass++;
    n_total++; if (state_o !== 2'd3) $display("FAIL halt_state: got %0d want 3", state_o); else n_pass++;
    n_total++; if (ctl !== C_HOLD) $display("FAIL halt_ctl: got %b want %b", ctl, C_HOLD); else n_pass++;
    ex_redirect_i = 1'b1; #1;
    n_total++; if (ctl !== C_RDR) $display("FAIL halt_rdr: got %b want %b", ctl, C_RDR); else n_pass++;
    ex_redirect_i = 1'b0; mem_req_i = 1'b1; imem_ready_i = 1'b0; set_load_use(); #1;
    n_total++; if (ctl !== C_HOLD) $display("FAIL halt_ignore: got %b want %b", ctl, C_HOLD); else n_pass++;
    tick();
    n_total++; if (state_o !== 2'd3) $display("FAIL halt_stay: got %0d want 3", state_o); else n_pass++;
    n_total++; if (stall_cnt_o !== 32'd5) $display("FAIL halt_cnt: got %0d want 5", stall_cnt_o); else n_pass++;
    idle(); halt_req_i = 1'b1; resume_i = 1'b1; #1;
    tick(); resume_i = 1'b0; #1;
    n_total++; if (state_o !== 2'd0) $display("FAIL resume_state: got %0d want 0", state_o); else n_pass++;
    tick(); halt_req_i = 1'b0; #1;
    n_total++; if (state_o !== 2'd2) $display("FAIL rehalt_state: got %0d want 2", state_o); else n_pass++;
    mem_req_i = 1'b1; #1;
    n_total++; if (ctl !== C_MEM) $display("FAIL drain_mem_ctl: got %b want %b", ctl, C_MEM); else n_pass++;
    tick();
    n_total++; if (state_o !== 2'd1) $display("FAIL drain_mw_state: got %0d want 1", state_o); else n_pass++;
    mem_ack_i = 1'b1; #1;
    tick(); idle(); #1;
    n_total++; if (state_o !== 2'd2) $display("FAIL drain_ret_state: got %0d want 2", state_o); else n_pass++;
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    tick(); idle(); mem_req_i = 1'b1; #1;
    tick();
    tick();
    tick();
    n_total++; if (state_o !== 2'd1) $display("FAIL rmw_pre_state: got %0d want 1", state_o); else n_pass++;
    idle(); n_rst = 1'b0; #1;
    n_total++; if (state_o !== 2'd0) $display("FAIL rmw_state: got %0d want 0", state_o); else n_pass++;
    n_total++; if (stall_cnt_o !== 32'd0) $display("FAIL rmw_cnt: got %0d want 0", stall_cnt_o); else n_pass++;
    n_total++; if (ctl !== C_NONE) $display("FAIL rmw_ctl: got %b want %b", ctl, C_NONE); else n_pass++;
    tick();
    n_rst = 1'b1;
    tick();
    n_total++; if (state_o !== 2'd0) $display("FAIL rmw_after_state: got %0d want 0", state_o); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_redirect();
    test_mem_wait();
    test_timeout();
    test_halt_drain();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush scheduler for the 5-stage pipeline. It drives the `stall`/`flush` inputs of the IF/ID, ID/EX and EX/MEM stage registers, the PC hold and the MEM/WB bubble. It resolves four event classes:

- load-use hazards
- EX-stage redirects (taken branch or jump)
- instruction-fetch and data-memory wait states
- a debug halt/resume handshake that drains the pipeline

## Interface

Parameters:
- DRAIN_CYCLES, 4: non-stalled cycles spent in DRAIN before reporting halted (ID, EX, MEM, WB).
- TIMEOUT, 255: MEM_WAIT cycle count at which `mem_timeout_o` sets.
- CNT_W, 32: width of the stall performance counter.

Ports:
- clk_i  in  1  clock.
- n_rst  in  1  reset, asynchronous, active-low.
- id_rs1_i / id_rs2_i  in  5  source registers of the instruction in ID.
- id_rs1_used_i / id_rs2_used_i  in  1  the ID instruction reads rs1 / rs2.
- ex_rd_i  in  5  destination register of the instruction in EX.
- ex_memread_en_i  in  1  the EX instruction is a load.
- ex_redirect_i  in  1  EX resolved a taken branch or jump; the PC loads the target this cycle.
- imem_ready_i  in  1  fetch data is valid this cycle.
- mem_req_i  in  1  the MEM-stage instruction accesses data memory.
- mem_ack_i  in  1  data memory completes the access this cycle.
- halt_req_i  in  1  debug halt request (level).
- resume_i  in  1  debug resume (pulse).
- pc_stall_o  out  1  hold the PC.
- if_id_stall_o / if_id_flush_o  out  1  IF/ID control.
- id_ex_stall_o / id_ex_flush_o  out  1  ID/EX control.
- ex_mem_stall_o  out  1  EX/MEM hold.
- mem_wb_flush_o  out  1  insert a bubble into MEM/WB.
- halted_o  out  1  the pipeline is drained and halted.
- mem_timeout_o  out  1  sticky memory-timeout error.
- state_o  out  2  FSM state: RUN=0, MEM_WAIT=1, DRAIN=2, HALTED=3.
- stall_cnt_o  out  CNT_W  count of PC-stall cycles.

## Operation

Derived terms:
- mem_hold = mem_req_i & !mem_ack_i.
- load_use = ex_memread_en_i & ex_rd_i != 0 & ((id_rs1_used_i & id_rs1_i == ex_rd_i) | (id_rs2_used_i & id_rs2_i == ex_rd_i)).

Output priority is highest first. All outputs not listed in a row are 0.

1. mem_hold, in any state except HALTED: assert pc_stall, if_id_stall, id_ex_stall, ex_mem_stall and mem_wb_flush.
2. ex_redirect_i: assert if_id_flush and id_ex_flush. The PC is not stalled, even in DRAIN or HALTED.
3. load_use, in RUN or DRAIN: assert pc_stall, if_id_stall and id_ex_flush.
4. State DRAIN or HALTED: assert pc_stall and if_id_flush.
5. RUN with !imem_ready_i: assert pc_stall and if_id_flush.

FSM transitions:
- RUN: mem_hold → MEM_WAIT with ret_state=RUN. Otherwise halt_req_i → DRAIN with drain_cnt=DRAIN_CYCLES.
- MEM_WAIT:
  - wait_cnt increments each cycle and saturates at TIMEOUT.
  - When wait_cnt reaches TIMEOUT, mem_timeout_o sets and stays set until reset. The FSM keeps waiting.
  - mem_ack_i → ret_state, with wait_cnt cleared.
- DRAIN:
  - mem_hold → MEM_WAIT with ret_state=DRAIN.
  - drain_cnt decrements on cycles without mem_hold or load_use.
  - A decrement from 1 → HALTED.
  - halt_req_i deassertion does not abort the drain.
- HALTED: resume_i → RUN. The mem, load_use and imem inputs are ignored. resume_i takes precedence over a still-asserted halt_req_i, which is re-sampled in RUN the following cycle.

Other rules:
- resume_i is ignored outside HALTED.
- halted_o = (state == HALTED).
- stall_cnt_o increments, modulo 2^CNT_W, on every cycle where pc_stall_o=1 and state != HALTED.

## Timing

- All stall/flush outputs are combinational from the current inputs and state. They take effect at the next clk_i edge in the stage registers.
- A zero-wait memory access (mem_req_i & mem_ack_i in the same cycle) produces no stall and no MEM_WAIT entry.
- A load-use hazard inserts exactly one bubble. The cycle after, the load is in MEM and load_use is false.
- State, counters, halted_o and mem_timeout_o are registered. halted_o rises the cycle after the last drain decrement.
- Reset, asynchronous and valid mid-operation including during MEM_WAIT or DRAIN, forces:
  - state RUN
  - ret_state RUN
  - wait_cnt, drain_cnt and stall_cnt_o 0
  - mem_timeout_o 0, halted_o 0
- With all inputs 0 except imem_ready_i=1, every stall/flush output is 0 after reset.

## Test plan

- **Load-use:** ex_memread_en=1, ex_rd=5, id_rs2=5, id_rs2_used=1 for one cycle → pc_stall, if_id_stall and id_ex_flush are 1 for exactly 1 cycle; stall_cnt_o = 1.
- **Redirect beats load-use:** the load-use condition and ex_redirect_i=1 in the same cycle → if_id_flush=1, id_ex_flush=1, pc_stall=0, if_id_stall=0.
- **Memory wait:** mem_req held with mem_ack rising after 3 cycles → the four stall outputs and mem_wb_flush are 1 for 3 cycles; state_o sequence 1,1,1,0; zero-wait access → no stall.
- **Timeout:** TIMEOUT=4 with ack withheld for 10 cycles → mem_timeout_o rises on the cycle after wait_cnt reaches 4, stays 1 after ack, and clears only on n_rst.
- **Halt drain:** halt_req pulse in RUN with one load-use cycle during drain → halted_o rises 6 cycles after the request edge; in HALTED pc_stall=1 and if_id_flush=1; a resume_i pulse returns state_o to 0 the next cycle.
- **Reset mid-wait:** n_rst low for 1 cycle during MEM_WAIT with wait_cnt=2 → immediate state_o=0, stall_cnt_o=0, all stalls 0.
